// File: rtl/wavelet_seq_ctrl.sv
// DB10 wavelet/envelogram sequencer: clears the datapath, streams samples,
// flushes the filter taps and packs |coefficient| strobes into the envelogram RAM.
module wavelet_seq_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int FLUSH_LEN  = 64,
    parameter int CLR_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] n_samples,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] out_count,
    output logic              smp_rd_en,
    output logic [ADDR_W-1:0] smp_addr,
    input  logic [31:0]       smp_rd_data,
    output logic              wv_rst,
    output logic [31:0]       wv_data,
    input  logic [31:0]       wv_abs,
    input  logic              wv_we,
    output logic              env_we,
    output logic [ADDR_W-1:0] env_addr,
    output logic [31:0]       env_data
);

    localparam int MAXP = (FLUSH_LEN > CLR_CYCLES + 1) ? FLUSH_LEN : CLR_CYCLES + 1;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int CW   = (PW > ADDR_W) ? PW : ADDR_W;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CLR_LAST = cnt_t'(CLR_CYCLES);
    localparam cnt_t FL_LAST  = cnt_t'(FLUSH_LEN - 1);
    localparam cnt_t RD_ARM   = cnt_t'((CLR_CYCLES >= 2) ? CLR_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH
    } state_t;

    state_t            state, state_nx;
    cnt_t              cnt, cnt_nx;
    logic [ADDR_W-1:0] n_q, n_nx;
    logic              rd_valid, rd_valid_nx;
    logic              busy_nx, done_nx, ovf_nx;
    logic [ADDR_W-1:0] count_nx;
    logic              rd_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              rst_nx;
    logic [31:0]       data_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] eaddr_nx;
    logic [31:0]       edata_nx;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        n_nx        = n_q;
        busy_nx     = busy;
        done_nx     = done;
        ovf_nx      = ovf;
        count_nx    = out_count;
        rd_nx       = smp_rd_en;
        addr_nx     = smp_addr;
        rd_valid_nx = smp_rd_en;
        rst_nx      = 1'b1;
        data_nx     = rd_valid ? smp_rd_data : 32'd0;
        we_nx       = 1'b0;
        eaddr_nx    = env_addr;
        edata_nx    = env_data;

        // Read stream runs independently of the phase counter
        if (smp_rd_en) begin
            if (smp_addr == n_q - ADDR_W'(1)) begin
                rd_nx   = 1'b0;
                addr_nx = '0;
            end else begin
                addr_nx = smp_addr + ADDR_W'(1);
            end
        end

        if (wv_we && busy && wv_rst) begin
            if (&out_count) begin
                ovf_nx = 1'b1;
            end else begin
                we_nx    = 1'b1;
                eaddr_nx = out_count;
                edata_nx = wv_abs;
                count_nx = out_count + ADDR_W'(1);
            end
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    done_nx  = 1'b0;
                    ovf_nx   = 1'b0;
                    count_nx = '0;
                    n_nx     = n_samples;
                    if (n_samples == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = CLEAR;
                        cnt_nx   = '0;
                        busy_nx  = 1'b1;
                        rd_nx    = (CLR_CYCLES == 1);
                        addr_nx  = '0;
                    end
                end
            end
            CLEAR: begin
                if (cnt == CLR_LAST) begin
                    state_nx = FEED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                    rst_nx = 1'b0;
                end
                // Launch reads early so sample 0 lands right after the clear
                if (CLR_CYCLES >= 2 && cnt == RD_ARM) begin
                    rd_nx   = 1'b1;
                    addr_nx = '0;
                end
            end
            FEED: begin
                if (cnt == cnt_t'(n_q) - cnt_t'(1)) begin
                    state_nx = FLUSH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
            end
            FLUSH: begin
                if (cnt == FL_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + cnt_t'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort) begin
            state_nx    = IDLE;
            cnt_nx      = '0;
            busy_nx     = 1'b0;
            done_nx     = done;
            ovf_nx      = ovf;
            count_nx    = out_count;
            rd_nx       = 1'b0;
            addr_nx     = '0;
            rd_valid_nx = 1'b0;
            rst_nx      = 1'b1;
            data_nx     = 32'd0;
            we_nx       = 1'b0;
            eaddr_nx    = env_addr;
            edata_nx    = env_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            n_q       <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            out_count <= '0;
            smp_rd_en <= 1'b0;
            smp_addr  <= '0;
            wv_rst    <= 1'b1;
            wv_data   <= 32'd0;
            env_we    <= 1'b0;
            env_addr  <= '0;
            env_data  <= 32'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            n_q       <= n_nx;
            rd_valid  <= rd_valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            ovf       <= ovf_nx;
            out_count <= count_nx;
            smp_rd_en <= rd_nx;
            smp_addr  <= addr_nx;
            wv_rst    <= rst_nx;
            wv_data   <= data_nx;
            env_we    <= we_nx;
            env_addr  <= eaddr_nx;
            env_data  <= edata_nx;
        end
    end

endmodule

// File: tb/tb_wavelet_seq_ctrl.sv
// Bench for wavelet_seq_ctrl: cycle-timed reference expectations for a
// full-size instance plus a 3-bit-address instance for the full-RAM case.
module tb_wavelet_seq_ctrl;

    localparam int AW  = 8;
    localparam int CLR = 2;
    localparam int FL  = 4;
    localparam int SAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start, abort;
    logic [AW-1:0] n_samples;
    logic          busy, done, ovf;
    logic [AW-1:0] out_count;
    logic          smp_rd_en;
    logic [AW-1:0] smp_addr;
    logic [31:0]   smp_rd_data;
    logic          wv_rst;
    logic [31:0]   wv_data;
    logic [31:0]   wv_abs;
    logic          wv_we;
    logic          env_we;
    logic [AW-1:0] env_addr;
    logic [31:0]   env_data;

    logic           s_start, s_abort;
    logic [SAW-1:0] s_n;
    logic           s_busy, s_done, s_ovf;
    logic [SAW-1:0] s_count;
    logic           s_rd_en;
    logic [SAW-1:0] s_addr;
    logic [31:0]    s_rd_data;
    logic           s_wv_rst;
    logic [31:0]    s_wv_data;
    logic [31:0]    s_abs;
    logic           s_we;
    logic           s_env_we;
    logic [SAW-1:0] s_env_addr;
    logic [31:0]    s_env_data;

    logic [31:0] ram [0:255];

    int tests = 0;
    int fails = 0;

    wavelet_seq_ctrl #(.ADDR_W(AW), .FLUSH_LEN(FL), .CLR_CYCLES(CLR)) u_dut (
        .CLK(clk), .RST(rst_n), .start(start), .abort(abort),
        .n_samples(n_samples), .busy(busy), .done(done), .ovf(ovf),
        .out_count(out_count), .smp_rd_en(smp_rd_en), .smp_addr(smp_addr),
        .smp_rd_data(smp_rd_data), .wv_rst(wv_rst), .wv_data(wv_data),
        .wv_abs(wv_abs), .wv_we(wv_we), .env_we(env_we),
        .env_addr(env_addr), .env_data(env_data)
    );

    wavelet_seq_ctrl #(.ADDR_W(SAW), .FLUSH_LEN(FL), .CLR_CYCLES(CLR)) u_small (
        .CLK(clk), .RST(rst_n), .start(s_start), .abort(s_abort),
        .n_samples(s_n), .busy(s_busy), .done(s_done), .ovf(s_ovf),
        .out_count(s_count), .smp_rd_en(s_rd_en), .smp_addr(s_addr),
        .smp_rd_data(s_rd_data), .wv_rst(s_wv_rst), .wv_data(s_wv_data),
        .wv_abs(s_abs), .wv_we(s_we), .env_we(s_env_we),
        .env_addr(s_env_addr), .env_data(s_env_data)
    );

    // Synchronous sample RAM: data valid the cycle after the read
    always @(posedge clk) begin
        if (smp_rd_en) smp_rd_data <= ram[smp_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One run from a start pulse; expectations come from the cycle budget
    // 1 + CLR + n + 1 + FL with the clear pulse on cycles 2..CLR+1.
    task automatic do_run(input int n, input int fill, input int smode,
                          input int abort_at, input int busy_start_at);
        int L, done_t, last, cnt_w, k, paddr;
        bit pend, s, ab, e_busy, e_rst, e_rd, e_done;
        logic [31:0] pdata, e_wv;
        for (int i = 0; i < n; i++) ram[i] = (fill == 0) ? 32'(i - 4) : $urandom;
        L      = CLR + n + 1 + FL;
        done_t = L + 1;
        last   = (abort_at > 0) ? abort_at + 5 : done_t + 2;
        cnt_w  = 0;
        k      = 0;
        pend   = 0;
        paddr  = 0;
        pdata  = 0;
        n_samples = AW'(n);
        start     = 1'b1;
        for (int t = 1; t <= last; t++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            wv_we = 1'b0;
            ab     = (abort_at > 0) && (t > abort_at);
            e_busy = !ab && t <= L;
            e_rst  = ab || t < 2 || t > CLR + 1;
            e_rd   = !ab && t >= CLR && t <= CLR + n - 1;
            e_wv   = (!ab && t >= CLR + 2 && t <= CLR + n + 1) ? ram[t - CLR - 2] : 32'd0;
            e_done = !ab && t >= done_t;
            chk($sformatf("busy@%0d", t), 32'(busy), 32'(e_busy));
            chk($sformatf("done@%0d", t), 32'(done), 32'(e_done));
            chk($sformatf("wv_rst@%0d", t), 32'(wv_rst), 32'(e_rst));
            chk($sformatf("smp_rd_en@%0d", t), 32'(smp_rd_en), 32'(e_rd));
            if (e_rd) chk($sformatf("smp_addr@%0d", t), 32'(smp_addr), 32'(t - CLR));
            chk($sformatf("wv_data@%0d", t), wv_data, e_wv);
            chk($sformatf("env_we@%0d", t), 32'(env_we), 32'(pend));
            if (pend) begin
                chk($sformatf("env_addr@%0d", t), 32'(env_addr), 32'(paddr));
                chk($sformatf("env_data@%0d", t), env_data, pdata);
            end
            chk($sformatf("out_count@%0d", t), 32'(out_count), 32'(cnt_w));
            chk($sformatf("ovf@%0d", t), 32'(ovf), 32'd0);
            if (t == busy_start_at) begin
                start     = 1'b1;
                n_samples = AW'($urandom_range(1, 50));
            end
            if (t == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
            end
            if (smode == 1) s = (t % 8 == 0);
            else if (smode == 2) s = ($urandom_range(0, 2) == 0);
            else s = 0;
            pend = 0;
            if (s) begin
                wv_we  = 1'b1;
                wv_abs = (smode == 1) ? 32'h100 + 32'(k) : $urandom;
                k++;
                if (e_busy && e_rst && t != abort_at) begin
                    pend  = 1;
                    paddr = cnt_w;
                    pdata = wv_abs;
                    cnt_w++;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        wv_we = 1'b0;
    endtask

    initial begin
        int scnt, k;
        bit spend, sovf;
        int spaddr;
        logic [31:0] spdata;

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; n_samples = '0;
        wv_abs = 32'd0; wv_we = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_n = '0;
        s_abs = 32'd0; s_we = 1'b0; s_rd_data = 32'd0;
        smp_rd_data = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst out_count", 32'(out_count), 32'd0);
        chk("rst smp_rd_en", 32'(smp_rd_en), 32'd0);
        chk("rst smp_addr", 32'(smp_addr), 32'd0);
        chk("rst wv_rst", 32'(wv_rst), 32'd1);
        chk("rst wv_data", wv_data, 32'd0);
        chk("rst env_we", 32'(env_we), 32'd0);
        chk("rst env_addr", 32'(env_addr), 32'd0);
        chk("rst env_data", env_data, 32'd0);
        chk("rst s_wv_rst", 32'(s_wv_rst), 32'd1);
        chk("rst s_busy", 32'(s_busy), 32'd0);
        rst_n = 1'b1;

        // Idle with random strobes: nothing may be captured or read
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle smp_rd_en", 32'(smp_rd_en), 32'd0);
            chk("idle env_we", 32'(env_we), 32'd0);
            chk("idle out_count", 32'(out_count), 32'd0);
            wv_we  = 1'(($urandom >> 3) & 1);
            wv_abs = $urandom;
        end
        wv_we = 1'b0;

        // Ramp samples, start pulsed mid-run
        do_run(8, 0, 0, 0, 5);
        // Periodic strobes with 0x100+k data
        do_run(20, 1, 1, 0, 0);
        // Random runs
        do_run(1, 1, 2, 0, 0);
        do_run(int'($urandom_range(2, 30)), 1, 2, 0, 0);
        // Abort on 3rd feed cycle with start, then clean re-run
        do_run(10, 1, 2, CLR + 4, 0);
        do_run(6, 1, 2, 0, 0);
        do_run(12, 1, 2, 3, 0);

        // Zero-length run
        n_samples = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("n0 done", 32'(done), 32'd1);
        chk("n0 busy", 32'(busy), 32'd0);
        chk("n0 wv_rst", 32'(wv_rst), 32'd1);
        chk("n0 out_count", 32'(out_count), 32'd0);
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            chk("n0 busy hold", 32'(busy), 32'd0);
            chk("n0 wv_rst hold", 32'(wv_rst), 32'd1);
            chk("n0 smp_rd_en", 32'(smp_rd_en), 32'd0);
            chk("n0 done hold", 32'(done), 32'd1);
        end

        // Envelogram RAM full on the 3-bit instance: 9 strobes, 7 writes
        s_n = 3'd5;
        s_start = 1'b1;
        scnt = 0; k = 0; spend = 0; sovf = 0; spaddr = 0; spdata = 0;
        for (int t = 1; t <= 15; t++) begin
            @(posedge clk);
            #1;
            s_start = 1'b0;
            s_we = 1'b0;
            chk($sformatf("s_busy@%0d", t), 32'(s_busy), 32'(t <= 12));
            chk($sformatf("s_done@%0d", t), 32'(s_done), 32'(t >= 13));
            chk($sformatf("s_env_we@%0d", t), 32'(s_env_we), 32'(spend));
            if (spend) begin
                chk($sformatf("s_env_addr@%0d", t), 32'(s_env_addr), 32'(spaddr));
                chk($sformatf("s_env_data@%0d", t), s_env_data, spdata);
            end
            chk($sformatf("s_count@%0d", t), 32'(s_count), 32'(scnt));
            chk($sformatf("s_ovf@%0d", t), 32'(s_ovf), 32'(sovf));
            spend = 0;
            if (t >= 4 && t <= 12) begin
                s_we  = 1'b1;
                s_abs = 32'h200 + 32'(k);
                k++;
                if (scnt < 7) begin
                    spend  = 1;
                    spaddr = scnt;
                    spdata = s_abs;
                    scnt++;
                end else begin
                    sovf = 1;
                end
            end
        end
        s_we = 1'b0;
        chk("s_final count", 32'(s_count), 32'd7);
        chk("s_final ovf", 32'(s_ovf), 32'd1);

        // Reset mid-run drops the pending write
        for (int i = 0; i < 10; i++) ram[i] = $urandom;
        n_samples = AW'(10);
        start = 1'b1;
        for (int t = 1; t <= CLR + 4; t++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            wv_we = 1'b0;
            if (t == CLR + 4) chk("mid env_we", 32'(env_we), 32'd1);
            if (t == CLR + 3) begin
                wv_we = 1'b1;
                wv_abs = 32'hABCD;
            end
            if (t == CLR + 4) begin
                wv_we = 1'b1;
                wv_abs = 32'h1234;
                rst_n = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wv_we = 1'b0;
        chk("rstmid env_we", 32'(env_we), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid done", 32'(done), 32'd0);
        chk("rstmid out_count", 32'(out_count), 32'd0);
        chk("rstmid wv_rst", 32'(wv_rst), 32'd1);
        chk("rstmid smp_rd_en", 32'(smp_rd_en), 32'd0);
        chk("rstmid wv_data", wv_data, 32'd0);

        // Normal run after the reset
        do_run(5, 1, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
